// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and frame constants shared by transmitter and receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam int UART_DATA_W = 8;
  localparam int UART_FRAME_BITS = UART_DATA_W + 2;
  function automatic int frame_cycles(int clk_div, int data_w);
    return (data_w + 2) * clk_div;
  endfunction
endpackage

// File: rtl/uart_tx_8n1_if.sv
// uart_tx_8n1_if: valid/ready byte handshake into the transmitter
interface uart_tx_8n1_if import uart_pkg::*; #(parameter int DATA_W = UART_DATA_W);
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divider that pulses bit_end on the last clk of every serial bit
module uart_baud_tick #(parameter int CLK_DIV = 16) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  assign bit_end = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    cnt <= (!rst_n || clr || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serial transmitter with registered txd and valid/ready byte input
module uart_tx_8n1 import uart_pkg::*; #(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_8n1_if.slave    s,
  output logic            txd,
  output logic            busy
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  uart_state_t state, state_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic clr, bit_end, txd_n;
  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst_n(rst_n), .clr(clr), .bit_end(bit_end));
  assign s.tx_ready = state == IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      bit_cnt <= bit_n;
      txd     <= txd_n;
    end
  end
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_n   = bit_cnt;
    clr     = 1'b0;
    case (state)
      IDLE: if (s.tx_valid) begin
        state_n = START;
        shift_n = s.tx_data;
        clr     = 1'b1;
      end
      START: state_n = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        shift_n = shift >> 1;
        bit_n   = bit_cnt == BW'(DATA_W - 1) ? '0 : bit_cnt + 1'b1;
        state_n = bit_cnt == BW'(DATA_W - 1) ? STOP : DATA;
      end
      STOP: state_n = bit_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    txd_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
  end
endmodule
